// File: rtl/regfile_banked_pkg.sv
// Shared constants for the register file, ALU and control unit:
// flag bit positions and default datapath geometry.
package regfile_pkg;
  localparam int FLAG_W    = 4;
  localparam int FLAG_Z    = 0;
  localparam int FLAG_N    = 1;
  localparam int FLAG_C    = 2;
  localparam int FLAG_V    = 3;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREGS = 16;
endpackage

// File: rtl/regfile_banked_flag_reg.sv
// N-bit status register with an independent load enable per bit and
// asynchronous clear.
module flag_reg #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] ld,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (ld[i]) q[i] <= d[i];
      end
    end
  end

endmodule

// File: rtl/regfile_banked.sv
// Two-bank register file: two combinational read ports, two write ports
// (B wins on collision), optional write-to-read bypass, bank swap, flags.
module regfile_banked
  import regfile_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NREGS   = DEF_NREGS,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [AW-1:0]     wa_a,
  input  logic [AW-1:0]     wa_b,
  input  logic [WIDTH-1:0]  wd_a,
  input  logic [WIDTH-1:0]  wd_b,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  input  logic              bank_swap,
  output logic              bank_q,
  input  logic [FLAG_W-1:0] flag_ld,
  input  logic [FLAG_W-1:0] flag_d,
  output logic [FLAG_W-1:0] flag_q
);

  logic [WIDTH-1:0] mem [2][NREGS];
  logic             wen_a;
  logic             wen_b;
  logic [WIDTH-1:0] raw1;
  logic [WIDTH-1:0] raw2;

  // Writes to r0 are dropped outright when r0 is hardwired to zero,
  // so they can neither land in storage nor feed the bypass.
  assign wen_a = we_a && !(ZERO_R0 && (wa_a == '0));
  assign wen_b = we_b && !(ZERO_R0 && (wa_b == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NREGS; i++) begin
          mem[b][i] <= '0;
        end
      end
      bank_q <= 1'b0;
    end else begin
      // Port B is assigned last so it takes the entry on an address collision.
      if (wen_a) mem[bank_q][wa_a] <= wd_a;
      if (wen_b) mem[bank_q][wa_b] <= wd_b;
      if (bank_swap) bank_q <= ~bank_q;
    end
  end

  function automatic logic [WIDTH-1:0] read_mux(
    input logic [WIDTH-1:0] raw,
    input logic [AW-1:0]    ra,
    input logic             byp_en,
    input logic             a_en,
    input logic [AW-1:0]    a_addr,
    input logic [WIDTH-1:0] a_data,
    input logic             b_en,
    input logic [AW-1:0]    b_addr,
    input logic [WIDTH-1:0] b_data
  );
    logic [WIDTH-1:0] v;
    v = raw;
    if (byp_en) begin
      if (a_en && (a_addr == ra)) v = a_data;
      if (b_en && (b_addr == ra)) v = b_data;
    end
    if (ZERO_R0 && (ra == '0)) v = '0;
    return v;
  endfunction

  assign raw1 = mem[bank_q][ra1];
  assign raw2 = mem[bank_q][ra2];

  // Bypass is suppressed during reset so rd reads zero while cleared.
  always_comb begin
    rd1 = read_mux(raw1, ra1, BYPASS && !reset, wen_a, wa_a, wd_a, wen_b, wa_b, wd_b);
    rd2 = read_mux(raw2, ra2, BYPASS && !reset, wen_a, wa_a, wd_a, wen_b, wa_b, wd_b);
  end

  flag_reg #(
    .N(FLAG_W)
  ) u_flags (
    .clk  (clk),
    .reset(reset),
    .ld   (flag_ld),
    .d    (flag_d),
    .q    (flag_q)
  );

endmodule
